// File: rtl/stopwatch_ctrl_if.sv
// Bundle of the stopwatch controller's user-pulse inputs and display outputs.
// Optional macro: STOPWATCH_COUNTDOWN_EN adds the 'dir' count-direction signal.
interface stopwatch_ctrl_if;
  logic        start_stop;
  logic        lap;
  logic        clr;
  logic        load;
  logic [15:0] preset;
`ifdef STOPWATCH_COUNTDOWN_EN
  logic        dir;
`endif
  logic [15:0] time_q;
  logic [15:0] disp;
  logic        running;
  logic        lap_active;
  logic        ovf;

  // Button/preset source side (testbench or upstream debouncer)
  modport master (
    output start_stop, lap, clr, load, preset,
`ifdef STOPWATCH_COUNTDOWN_EN
    output dir,
`endif
    input  time_q, disp, running, lap_active, ovf
  );

  // Controller side
  modport slave (
    input  start_stop, lap, clr, load, preset,
`ifdef STOPWATCH_COUNTDOWN_EN
    input  dir,
`endif
    output time_q, disp, running, lap_active, ovf
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: prescaler, BCD mm:ss digit chain, run/pause/lap FSM
// and lap capture register.
// Optional macro: STOPWATCH_COUNTDOWN_EN adds count-down via bus.dir; when a
// count-down reaches 00:00 the watch pauses and flags ovf.
module stopwatch_ctrl #(
  parameter int PRESCALE = 100,
  parameter int PS_W     = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  stopwatch_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_e;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  state_e          state_q;
  logic [15:0]     time_q;
  logic [15:0]     lapReg_q;
  logic [PS_W-1:0] ps_q;
  logic            running_q;
  logic            lapActive_q;
  logic            ovf_q;

  logic            counting;
  logic            tick;
  logic            atTop;
  logic [15:0]     countUp_d;
  logic [15:0]     presetClamped;

  // Clamp an out-of-range BCD digit to the largest legal value for its place
  function automatic logic [3:0] clampDigit(input logic [3:0] d, input logic [3:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  assign counting = (state_q == RUN) || (state_q == LAP);
  assign tick     = counting && (ps_q == PS_LAST);
  assign atTop    = (time_q == 16'h5959);

  assign presetClamped = {clampDigit(bus.preset[15:12], 4'd5),
                          clampDigit(bus.preset[11:8],  4'd9),
                          clampDigit(bus.preset[7:4],   4'd5),
                          clampDigit(bus.preset[3:0],   4'd9)};

  // Count-up chain: each digit advances when all lower digits sit at their terminal value
  always_comb begin
    countUp_d = time_q;
    countUp_d[3:0] = (time_q[3:0] == 4'd9) ? 4'd0 : time_q[3:0] + 4'd1;
    if (time_q[3:0] == 4'd9)
      countUp_d[7:4] = (time_q[7:4] == 4'd5) ? 4'd0 : time_q[7:4] + 4'd1;
    if (time_q[7:0] == 8'h59)
      countUp_d[11:8] = (time_q[11:8] == 4'd9) ? 4'd0 : time_q[11:8] + 4'd1;
    if (time_q[11:0] == 12'h959)
      countUp_d[15:12] = (time_q[15:12] == 4'd5) ? 4'd0 : time_q[15:12] + 4'd1;
  end

`ifdef STOPWATCH_COUNTDOWN_EN
  logic [15:0] countDown_d;
  logic        zeroHit;

  // Count-down chain: each digit borrows when all lower digits sit at zero
  always_comb begin
    countDown_d = time_q;
    countDown_d[3:0] = (time_q[3:0] == 4'd0) ? 4'd9 : time_q[3:0] - 4'd1;
    if (time_q[3:0] == 4'd0)
      countDown_d[7:4] = (time_q[7:4] == 4'd0) ? 4'd5 : time_q[7:4] - 4'd1;
    if (time_q[7:0] == 8'h00)
      countDown_d[11:8] = (time_q[11:8] == 4'd0) ? 4'd9 : time_q[11:8] - 4'd1;
    if (time_q[11:0] == 12'h000)
      countDown_d[15:12] = (time_q[15:12] == 4'd0) ? 4'd5 : time_q[15:12] - 4'd1;
  end

  assign zeroHit = tick && bus.dir && ((time_q == 16'h0000) || (countDown_d == 16'h0000));
`endif

  // FSM, prescaler, time counter, lap capture and status flags in one registered block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      time_q      <= 16'h0000;
      lapReg_q    <= 16'h0000;
      ps_q        <= '0;
      running_q   <= 1'b0;
      lapActive_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (bus.clr) begin
      state_q     <= IDLE;
      time_q      <= 16'h0000;
      ps_q        <= '0;
      running_q   <= 1'b0;
      lapActive_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (counting)
        ps_q <= tick ? '0 : ps_q + PS_ONE;

      if (tick) begin
`ifdef STOPWATCH_COUNTDOWN_EN
        if (bus.dir) begin
          time_q <= countDown_d;
        end else
`endif
        begin
          time_q <= countUp_d;
          if (atTop)
            ovf_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE, PAUSE: begin
          if (bus.load) begin
            time_q <= presetClamped;
            ps_q   <= '0;
          end
          if (bus.start_stop) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.start_stop) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end else if (bus.lap) begin
            state_q     <= LAP;
            lapReg_q    <= time_q;
            lapActive_q <= 1'b1;
          end
        end
        LAP: begin
          if (bus.lap) begin
            state_q     <= RUN;
            lapActive_q <= 1'b0;
          end else if (bus.start_stop) begin
            state_q     <= PAUSE;
            running_q   <= 1'b0;
            lapActive_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

`ifdef STOPWATCH_COUNTDOWN_EN
      if (zeroHit) begin
        state_q     <= PAUSE;
        time_q      <= 16'h0000;
        running_q   <= 1'b0;
        lapActive_q <= 1'b0;
        ovf_q       <= 1'b1;
      end
`endif
    end
  end

  assign bus.time_q     = time_q;
  assign bus.disp       = lapActive_q ? lapReg_q : time_q;
  assign bus.running    = running_q;
  assign bus.lap_active = lapActive_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl with a 4-cycle prescaler.
// Optional macro: STOPWATCH_COUNTDOWN_EN enables the count-down steps.
module tb_stopwatch_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(
    .PRESCALE (4),
    .PS_W     (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock; inputs change on the falling edge, outputs are sampled 1 ns after the rising edge
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of pulses, let the rising edge take them, then drop them again
  task automatic applyStimulus(input logic ss, input logic lp, input logic cl,
                               input logic ld, input logic [15:0] pre);
    @(negedge clk);
    bus.start_stop = ss;
    bus.lap        = lp;
    bus.clr        = cl;
    bus.load       = ld;
    bus.preset     = pre;
    @(posedge clk);
    #1;
    bus.start_stop = 1'b0;
    bus.lap        = 1'b0;
    bus.clr        = 1'b0;
    bus.load       = 1'b0;
  endtask

  // Let n rising edges pass with no pulses, ending 1 ns after the last one
  task automatic waitClocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // The whole directed sequence: each step's expectations are worked out from a fresh prescaler
  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.start_stop = 1'b0;
    bus.lap        = 1'b0;
    bus.clr        = 1'b0;
    bus.load       = 1'b0;
    bus.preset     = 16'h0000;
`ifdef STOPWATCH_COUNTDOWN_EN
    bus.dir        = 1'b0;
`endif
    $display("[TB] starting stopwatch_ctrl directed sequence");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitClocks(1);

    checkOutput("reset_time",    bus.time_q,              16'h0000);
    checkOutput("reset_disp",    bus.disp,                16'h0000);
    checkOutput("reset_running", {15'd0, bus.running},    16'h0000);
    checkOutput("reset_lap",     {15'd0, bus.lap_active}, 16'h0000);
    checkOutput("reset_ovf",     {15'd0, bus.ovf},        16'h0000);

    // Ten prescaler periods make ten seconds, then pausing freezes the count
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    waitClocks(40);
    checkOutput("run40_time",    bus.time_q,           16'h0010);
    checkOutput("run40_running", {15'd0, bus.running}, 16'h0001);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    waitClocks(20);
    checkOutput("pause_time",    bus.time_q,           16'h0010);
    checkOutput("pause_running", {15'd0, bus.running}, 16'h0000);

    // Load is honoured in PAUSE; s1 wraps into m0 on the next tick
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0059);
    checkOutput("pause_load", bus.time_q, 16'h0059);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    waitClocks(4);
    checkOutput("wrap_0059", bus.time_q, 16'h0100);

    // m0 wraps into m1
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h0959);
    waitClocks(4);
    checkOutput("wrap_0959", bus.time_q, 16'h1000);

    // Load plus start together, 59:58 rolls over to 00:00 with sticky ovf
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h5958);
    waitClocks(4);
    checkOutput("top_5959", bus.time_q, 16'h5959);
    checkOutput("top_ovf0", {15'd0, bus.ovf}, 16'h0000);
    waitClocks(4);
    checkOutput("wrap_time",    bus.time_q,           16'h0000);
    checkOutput("wrap_ovf",     {15'd0, bus.ovf},     16'h0001);
    checkOutput("wrap_running", {15'd0, bus.running}, 16'h0001);
    waitClocks(4);
    checkOutput("wrap_continue", bus.time_q, 16'h0001);

    // Pause keeps ovf; clr with start_stop in PAUSE goes to IDLE and clears everything
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("pause_ovf_sticky", {15'd0, bus.ovf}, 16'h0001);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("clr_time",    bus.time_q,           16'h0000);
    checkOutput("clr_ovf",     {15'd0, bus.ovf},     16'h0000);
    checkOutput("clr_running", {15'd0, bus.running}, 16'h0000);
    waitClocks(8);
    checkOutput("clr_idle_hold", bus.time_q, 16'h0000);

    // Lap freezes the display while the live count keeps going
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h0005);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    waitClocks(12);
    checkOutput("lap_disp",   bus.disp,                16'h0005);
    checkOutput("lap_time",   bus.time_q,              16'h0008);
    checkOutput("lap_active", {15'd0, bus.lap_active}, 16'h0001);
    checkOutput("lap_running", {15'd0, bus.running},   16'h0001);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("unlap_disp",   bus.disp,                16'h0008);
    checkOutput("unlap_active", {15'd0, bus.lap_active}, 16'h0000);

    // Out-of-range preset digits clamp; load is ignored while running
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'hFA9C);
    checkOutput("clamp_load", bus.time_q, 16'h5959);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h1111);
    checkOutput("run_load_ignored", bus.time_q, 16'h5959);

    // Asynchronous reset mid-RUN clears outputs before the next clock edge
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
    waitClocks(2);
    checkOutput("pre_reset_time", bus.time_q, 16'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_time",    bus.time_q,           16'h0000);
    checkOutput("async_disp",    bus.disp,             16'h0000);
    checkOutput("async_running", {15'd0, bus.running}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    waitClocks(8);
    checkOutput("post_reset_idle", bus.time_q, 16'h0000);

`ifdef STOPWATCH_COUNTDOWN_EN
    // Count-down borrows across digits
    bus.dir = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h0100);
    waitClocks(4);
    checkOutput("down_borrow", bus.time_q, 16'h0059);

    // Count-down to 00:00 pauses and flags ovf, then holds
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h0002);
    waitClocks(4);
    checkOutput("down_one", bus.time_q, 16'h0001);
    waitClocks(4);
    checkOutput("down_zero_time",    bus.time_q,           16'h0000);
    checkOutput("down_zero_running", {15'd0, bus.running}, 16'h0000);
    checkOutput("down_zero_ovf",     {15'd0, bus.ovf},     16'h0001);
    waitClocks(8);
    checkOutput("down_zero_hold", bus.time_q, 16'h0000);
    bus.dir = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
